// File: rtl/expu_sum_accumulator.sv
// Softmax denominator accumulator: converts non-negative floats from the
// exponential unit to unsigned fixed point and sums them per vector.
module expu_sum_accumulator #(
  parameter int MANTISSA_BITS = 7,
  parameter int EXPONENT_BITS = 8,
  parameter int ACC_INT_BITS  = 8,
  parameter int ACC_FRAC_BITS = 16,
  parameter int COUNT_BITS    = 16,
  localparam int FLOAT_W      = MANTISSA_BITS + EXPONENT_BITS + 1,
  localparam int ACC_W        = ACC_INT_BITS + ACC_FRAC_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  last_i,
  input  logic [FLOAT_W-1:0]    float_i,
  output logic                  sum_valid_o,
  input  logic                  sum_ready_i,
  output logic [ACC_W-1:0]      sum_o,
  output logic [COUNT_BITS-1:0] count_o,
  output logic                  overflow_o
);

  localparam int BIAS   = (1 << (EXPONENT_BITS - 1)) - 1;
  localparam int SIG_W  = MANTISSA_BITS + 1;
  localparam int WIDE_W = ACC_W + SIG_W;

  typedef enum logic {ACCUM, DONE} state_e;
  state_e state_q, state_d;

  logic [ACC_W-1:0]         acc_q;
  logic [COUNT_BITS-1:0]    count_q;
  logic                     ovf_q;

  logic [EXPONENT_BITS-1:0] exp_f;
  logic [SIG_W-1:0]         sig;
  logic                     unused_sign;
  logic [WIDE_W-1:0]        wide;
  logic [ACC_W-1:0]         term;
  logic                     term_sat;
  logic [ACC_W:0]           add_full;
  logic [ACC_W-1:0]         acc_nxt;
  logic                     add_sat;
  int                       shamt;

  // Exponential-unit outputs are non-negative; the sign bit is dropped.
  assign unused_sign = float_i[FLOAT_W-1];
  assign exp_f       = float_i[FLOAT_W-2 -: EXPONENT_BITS];
  assign sig         = {1'b1, float_i[MANTISSA_BITS-1:0]};

  always_comb begin
    term     = '0;
    term_sat = 1'b0;
    wide     = '0;
    shamt    = int'(exp_f) - BIAS - MANTISSA_BITS + ACC_FRAC_BITS;
    if (exp_f == '0) begin
      term = '0;
    end else if (exp_f == '1) begin
      term_sat = 1'b1;
    end else if (shamt >= ACC_W) begin
      term_sat = 1'b1;
    end else if (shamt >= 0) begin
      // Leading one can land above the accumulator; any such bit saturates.
      wide = WIDE_W'(sig) << shamt;
      if (|wide[WIDE_W-1:ACC_W]) term_sat = 1'b1;
      else                       term     = wide[ACC_W-1:0];
    end else if (-shamt < SIG_W) begin
      term = ACC_W'(sig >> (-shamt));
    end
    if (term_sat) term = '1;
  end

  assign add_full = {1'b0, acc_q} + {1'b0, term};
  assign add_sat  = add_full[ACC_W] | term_sat;
  assign acc_nxt  = add_sat ? '1 : add_full[ACC_W-1:0];

  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    sum_valid_o = 1'b0;
    case (state_q)
      ACCUM: begin
        ready_o = 1'b1;
        if (valid_i && last_i) state_d = DONE;
      end
      DONE: begin
        sum_valid_o = 1'b1;
        if (sum_ready_i) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    if (clear_i) state_d = ACCUM;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ACCUM;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear_i || (state_q == DONE && sum_ready_i)) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == ACCUM && valid_i) begin
      acc_q   <= acc_nxt;
      ovf_q   <= ovf_q | add_sat;
      if (count_q != '1) count_q <= count_q + 1'b1;
    end
  end

  assign sum_o      = acc_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule
